udm_csr_bank: RTL and testbench

UDM_CSR_BANK -- requirements
Module: udm_csr_bank

---
 rtl/udm_csr_bank.sv | 102 ++++++++++
 tb/tb_udm_csr_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/udm_csr_bank.sv
// Memory-mapped CSR bank: RW registers, RO inputs, a free-running cycle counter and an unmapped tail.
// Define UDM_CSR_RO_SYNC_EN to pass ro_regs_bi through a 2-flop synchroniser before the read mux.
module udm_csr_bank #(
  parameter logic [31:0] BASE_ADDR      = 32'h00000000,
  parameter int          NUM_RW         = 4,
  parameter int          NUM_RO         = 2,
  parameter logic [31:0] RW_RST_VAL     = 32'h00000000,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hDEADBEEF,
  localparam int         RO_W           = (NUM_RO > 0) ? NUM_RO * 32 : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bus_req_i,
  input  logic                   bus_we_i,
  input  logic [31:0]            bus_addr_bi,
  input  logic [3:0]             bus_be_bi,
  input  logic [31:0]            bus_wdata_bi,
  output logic                   bus_ack_o,
  output logic                   bus_resp_o,
  output logic [31:0]            bus_rdata_bo,
  output logic [NUM_RW*32-1:0]   rw_regs_bo,
  output logic [NUM_RW-1:0]      wr_stb_o,
  input  logic [RO_W-1:0]        ro_regs_bi
);

  localparam int NUM_WORDS = NUM_RW + NUM_RO + 1 + 8;
  localparam int CYCLE_IDX = NUM_RW + NUM_RO;
  localparam logic [31:0] WIN_BYTES = 32'(4 * NUM_WORDS);

  logic [31:0] rw_q [NUM_RW];
  logic [31:0] cycle_q;
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic        in_window;
  logic [31:0] rd_sel;
  logic [RO_W-1:0] ro_view;

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both ends
  assign offset    = bus_addr_bi - BASE_ADDR;
  assign in_window = (offset < WIN_BYTES);
  assign word_idx  = offset[31:2];
  assign bus_ack_o = bus_req_i & in_window & ~rst_i;

`ifdef UDM_CSR_RO_SYNC_EN
  logic [RO_W-1:0] ro_meta_q;
  logic [RO_W-1:0] ro_sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ro_meta_q <= '0;
      ro_sync_q <= '0;
    end else begin
      ro_meta_q <= ro_regs_bi;
      ro_sync_q <= ro_meta_q;
    end
  end

  assign ro_view = ro_sync_q;
`else
  assign ro_view = ro_regs_bi;
`endif

  always_comb begin
    rd_sel = UNMAPPED_RDATA;
    for (int i = 0; i < NUM_RW; i++) begin
      if (word_idx == 30'(i)) rd_sel = rw_q[i];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (word_idx == 30'(NUM_RW + j)) rd_sel = ro_view[32*j +: 32];
    end
    if (word_idx == 30'(CYCLE_IDX)) rd_sel = cycle_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= RW_RST_VAL;
      wr_stb_o     <= '0;
      cycle_q      <= '0;
      bus_resp_o   <= 1'b0;
      bus_rdata_bo <= '0;
    end else begin
      cycle_q      <= cycle_q + 32'd1;
      wr_stb_o     <= '0;
      bus_resp_o   <= bus_ack_o & ~bus_we_i;
      bus_rdata_bo <= (bus_ack_o & ~bus_we_i) ? rd_sel : 32'h0;
      // The strobe fires on any accepted write to the word, even with no byte enables set
      for (int i = 0; i < NUM_RW; i++) begin
        if (bus_ack_o && bus_we_i && (word_idx == 30'(i))) begin
          wr_stb_o[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (bus_be_bi[b]) rw_q[i][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
    assign rw_regs_bo[32*g +: 32] = rw_q[g];
  end

endmodule

// File: tb/tb_udm_csr_bank.sv
// Self-checking bench for udm_csr_bank: directed scenarios then random bus traffic against a word-level model.
module tb_udm_csr_bank;

  localparam logic [31:0] BASE       = 32'h00000000;
  localparam int          NUM_RW     = 4;
  localparam int          NUM_RO     = 2;
  localparam int          NUM_WORDS  = NUM_RW + NUM_RO + 1 + 8;
  localparam logic [31:0] UNMAPPED   = 32'hDEADBEEF;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  bus_req = 1'b0;
  logic                  bus_we = 1'b0;
  logic [31:0]           bus_addr = '0;
  logic [3:0]            bus_be = '0;
  logic [31:0]           bus_wdata = '0;
  logic                  bus_ack;
  logic                  bus_resp;
  logic [31:0]           bus_rdata;
  logic [NUM_RW*32-1:0]  rw_regs;
  logic [NUM_RW-1:0]     wr_stb;
  logic [NUM_RO*32-1:0]  ro_regs = '0;

  logic [31:0] rw_model [NUM_RW];
  logic [31:0] ro_model [NUM_RO];
  logic [31:0] model_cycle;

  int n_checks = 0;
  int n_fail   = 0;

  udm_csr_bank #(
    .BASE_ADDR      (BASE),
    .NUM_RW         (NUM_RW),
    .NUM_RO         (NUM_RO),
    .RW_RST_VAL     (32'h00000000),
    .UNMAPPED_RDATA (UNMAPPED)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus_req_i    (bus_req),
    .bus_we_i     (bus_we),
    .bus_addr_bi  (bus_addr),
    .bus_be_bi    (bus_be),
    .bus_wdata_bi (bus_wdata),
    .bus_ack_o    (bus_ack),
    .bus_resp_o   (bus_resp),
    .bus_rdata_bo (bus_rdata),
    .rw_regs_bo   (rw_regs),
    .wr_stb_o     (wr_stb),
    .ro_regs_bi   (ro_regs)
  );

  always #5 clk = ~clk;

  function automatic bit model_in_window(input logic [31:0] addr);
    longint off;
    off = longint'(addr) - longint'(BASE);
    return (off >= 0) && (off < 4 * NUM_WORDS);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx;
    idx = int'((addr - BASE) / 4);
    if (idx < NUM_RW)               return rw_model[idx];
    else if (idx < NUM_RW + NUM_RO) return ro_model[idx - NUM_RW];
    else if (idx == NUM_RW + NUM_RO) return model_cycle;
    else                            return UNMAPPED;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic req, input logic we,
                               input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    rst       = r;
    bus_req   = req;
    bus_we    = we;
    bus_addr  = addr;
    bus_be    = be;
    bus_wdata = wdata;
  endtask

  // One bus cycle: drive after a falling edge, predict, cross the rising edge, check at the next falling edge
  task automatic step(input logic r, input logic req, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata, input string tag,
                      output logic [31:0] rdata_seen);
    logic                 exp_ack;
    logic                 exp_resp;
    logic [31:0]          exp_rdata;
    logic [NUM_RW-1:0]    exp_stb;
    logic [NUM_RW*32-1:0] exp_regs;
    int                   idx;
    applyStimulus(r, req, we, addr, be, wdata);
    #1;
    exp_ack = req && !r && model_in_window(addr);
    checkOutput({tag, "_ack"}, 32'(bus_ack), 32'(exp_ack));
    exp_resp  = exp_ack && !we;
    exp_rdata = exp_resp ? model_read(addr) : 32'h0;
    exp_stb   = '0;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NUM_RW; i++) rw_model[i] = 32'h0;
      model_cycle = 32'h0;
    end else begin
      model_cycle = model_cycle + 32'd1;
      if (exp_ack && we) begin
        idx = int'((addr - BASE) / 4);
        if (idx < NUM_RW) begin
          exp_stb[idx] = 1'b1;
          for (int b = 0; b < 4; b++)
            if (be[b]) rw_model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < NUM_RW; i++) exp_regs[32*i +: 32] = rw_model[i];
    checkOutput({tag, "_resp"}, 32'(bus_resp), 32'(exp_resp));
    checkOutput({tag, "_rdata"}, bus_rdata, exp_rdata);
    checkOutput({tag, "_stb"}, 32'(wr_stb), 32'(exp_stb));
    for (int i = 0; i < NUM_RW; i++)
      checkOutput($sformatf("%s_rw%0d", tag, i), rw_regs[32*i +: 32], exp_regs[32*i +: 32]);
    rdata_seen = bus_rdata;
  endtask

  task automatic idle(input int n);
    logic [31:0] dummy;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "idle", dummy);
  endtask

  task automatic set_ro(input int j, input logic [31:0] val);
    ro_regs[32*j +: 32] = val;
    ro_model[j]         = val;
  endtask

  initial begin
    logic [31:0] rd, first_cyc, second_cyc, addr;
    logic        we;
    logic [3:0]  be;
    int          widx;

    for (int j = 0; j < NUM_RO; j++) ro_model[j] = 32'h0;
    @(negedge clk);

    step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "reset0", rd);
    step(1'b1, 1'b1, 1'b0, BASE, 4'h0, 32'h0, "reset_rd", rd);

    step(1'b0, 1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0, "cyc_first", rd);
    checkOutput("cycle_after_reset", rd, 32'h0);
    step(1'b0, 1'b1, 1'b0, BASE, 4'h0, 32'h0, "rd_base0", rd);
    checkOutput("rw0_after_reset", rd, 32'h0);
    checkOutput("rw_all_zero", 32'(rw_regs != '0), 32'h0);

    step(1'b0, 1'b1, 1'b1, BASE + 32'h4, 4'b0101, 32'h12345678, "wr_be0101", rd);
    checkOutput("stb_after_write", 32'(wr_stb), 32'h2);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0, "rd_after_wr", rd);
    checkOutput("rw1_merged", rd, 32'h00340078);
    step(1'b0, 1'b1, 1'b1, BASE + 32'h8, 4'b0000, 32'hFFFFFFFF, "wr_be0", rd);
    checkOutput("stb_no_bytes", 32'(wr_stb), 32'h4);

    set_ro(0, 32'hA5A5A5A5);
    set_ro(1, $urandom);
    idle(3);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0, "rd_ro0", rd);
    checkOutput("ro0_value", rd, 32'hA5A5A5A5);
    step(1'b0, 1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'h0, "wr_ro0", rd);

    step(1'b0, 1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0, "cyc_a", first_cyc);
    idle(4);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0, "cyc_b", second_cyc);
    checkOutput("cycle_delta", second_cyc - first_cyc, 32'd5);

    force dut.cycle_q = 32'hFFFFFFFF;
    model_cycle = 32'hFFFFFFFF;
    #1;
    release dut.cycle_q;
    idle(1);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0, "cyc_wrap", rd);
    checkOutput("cycle_wrapped", rd, 32'h00000001 - 32'd1);

    step(1'b0, 1'b1, 1'b0, BASE + 32'h1C, 4'h0, 32'h0, "rd_unmapped", rd);
    checkOutput("unmapped_value", rd, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b1, BASE + 32'h1000, 4'hF, 32'hCAFEF00D, "wr_outside", rd);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h1000, 4'h0, 32'h0, "rd_outside", rd);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h3C, 4'h0, 32'h0, "rd_edge_out", rd);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h38, 4'h0, 32'h0, "rd_edge_in", rd);

    step(1'b0, 1'b1, 1'b1, BASE + 32'h0, 4'hF, 32'h11111111, "wr_r0", rd);
    step(1'b0, 1'b1, 1'b1, BASE + 32'h8, 4'hF, 32'h33333333, "wr_r2", rd);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h0, 4'h0, 32'h0, "b2b_0", rd);
    checkOutput("b2b_first", rd, 32'h11111111);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0, "b2b_1", rd);
    checkOutput("b2b_second", rd, 32'h00340078);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h8, 4'h0, 32'h0, "b2b_2", rd);
    checkOutput("b2b_third", rd, 32'h33333333);
    step(1'b1, 1'b1, 1'b0, BASE + 32'h0, 4'h0, 32'h0, "rd_in_reset", rd);
    checkOutput("no_resp_in_reset", 32'(bus_resp), 32'h0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_ro(int'($urandom_range(0, NUM_RO - 1)), $urandom);
        idle(3);
      end
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)
        addr = BASE + 32'(4 * NUM_WORDS) + 32'($urandom_range(0, 255));
      else begin
        widx = int'($urandom_range(0, NUM_WORDS - 1));
        addr = BASE + 32'(4 * widx) + 32'($urandom_range(0, 3));
      end
      step(1'b0, 1'($urandom_range(0, 3) != 0), we, addr, be, $urandom, "rand", rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
